// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
//   Bundles the E/D-stage signals exchanged with the multiply/divide unit.
//   master: pipeline side (drives the op, operands and D-stage MD flag).
//   slave : md_unit_ctrl (drives start/busy, HI/LO, read data and stall request).
//   Signals:
//     E_mdOp    [3:0]  MD opcode in E (0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,
//                      5 MTHI,6 MTLO,7 MFHI,8 MFLO; 9-15 treated as NONE)
//     E_srcA    [31:0] forwarded rs operand
//     E_srcB    [31:0] forwarded rt operand
//     D_isMD           instruction in D is an MD-class op
//     E_start          arithmetic op accepted this cycle
//     busy             arithmetic op in flight
//     hi, lo    [31:0] architectural HI/LO
//     E_mdRead  [31:0] MFHI/MFLO read data
//     stall_req        hold D while the unit is starting or busy
interface md_unit_ctrl_if;
  logic [3:0]  E_mdOp;
  logic [31:0] E_srcA;
  logic [31:0] E_srcB;
  logic        D_isMD;
  logic        E_start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] E_mdRead;
  logic        stall_req;

  modport master (
    output E_mdOp, E_srcA, E_srcB, D_isMD,
    input  E_start, busy, hi, lo, E_mdRead, stall_req
  );

  modport slave (
    input  E_mdOp, E_srcA, E_srcB, D_isMD,
    output E_start, busy, hi, lo, E_mdRead, stall_req
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Multi-cycle multiply/divide unit with HI/LO registers, sequenced from E.
//   An arithmetic op (mult/multu/div/divu) accepted while idle has its result
//   computed into shadow registers at the accept edge; the unit then stays busy
//   for MULT_CYCLES or DIV_CYCLES cycles and commits the shadow values to HI/LO
//   on the last busy edge. MTHI/MTLO write HI/LO directly when idle; MFHI/MFLO
//   read them combinationally.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high; aborts any in-flight op
//     md     md_unit_ctrl_if.slave bundle (op, operands, D_isMD in;
//            E_start, busy, hi, lo, E_mdRead, stall_req out)
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_unit_ctrl_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] sh_hi_q, sh_hi_d;
  logic [31:0] sh_lo_q, sh_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_arith;
  logic        is_div;
  logic        start;

  logic [31:0] a;
  logic [31:0] b;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] div_bs;
  logic [31:0] div_bu;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign a = md.E_srcA;
  assign b = md.E_srcB;

  assign is_arith = (md.E_mdOp >= OP_MULT) && (md.E_mdOp <= OP_DIVU);
  assign is_div   = (md.E_mdOp == OP_DIV) || (md.E_mdOp == OP_DIVU);
  assign start    = is_arith && (state_q == IDLE);

  assign md.E_start   = start;
  assign md.busy      = (state_q == RUN);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.stall_req = md.D_isMD & (start | (state_q == RUN));
  assign md.E_mdRead  = (md.E_mdOp == OP_MFHI) ? hi_q :
                        (md.E_mdOp == OP_MFLO) ? lo_q : 32'd0;

  // The divisor is forced to 1 for divide-by-zero and for the one signed
  // overflow case so the dividers never see an undefined operation; those
  // cases are resolved explicitly in the result mux below.
  assign a_sx     = {{32{a[31]}}, a};
  assign b_sx     = {{32{b[31]}}, b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = {32'd0, a} * {32'd0, b};
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_bs   = (div_zero || div_ovf) ? 32'd1 : b;
  assign div_bu   = div_zero ? 32'd1 : b;
  assign quot_s   = $signed(a) / $signed(div_bs);
  assign rem_s    = $signed(a) % $signed(div_bs);
  assign quot_u   = a / div_bu;
  assign rem_u    = a % div_bu;

  // Divide-by-zero reloads the current HI/LO so the later commit is a no-op.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (md.E_mdOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic. MTHI/MTLO only take effect when idle; arithmetic ops
  // arriving while RUN are dropped because stall_req keeps them out of E.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_hi_d = res_hi;
          sh_lo_d = res_lo;
          cnt_d   = is_div ? DIV_N : MULT_N;
          state_d = RUN;
        end else if (md.E_mdOp == OP_MTHI) begin
          hi_d = a;
        end else if (md.E_mdOp == OP_MTLO) begin
          lo_d = a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl
//   Self-checking bench for md_unit_ctrl: directed scenarios followed by a
//   randomized op stream, all compared every cycle against a behavioural
//   model of HI/LO and the pending result with its commit cycle.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;

  // Behavioural model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_pending;
  int          cyc;
  int          commit_cyc;
  int          stall_count;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0:       w = 32'd0;
      1:       w = 32'hFFFF_FFFF;
      2:       w = 32'h8000_0000;
      3:       w = 32'($urandom_range(0, 20));
      4:       w = -32'($urandom_range(1, 20));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // Reference arithmetic from plain 64-bit integer rules
  task automatic model_compute(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    longint sa, sb, q, r, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p_hi = m_hi;
    p_lo = m_lo;
    case (op)
      4'd1: begin ps = sa * sb; p_hi = ps[63:32]; p_lo = ps[31:0]; end
      4'd2: begin pu = ua * ub; p_hi = pu[63:32]; p_lo = pu[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
      4'd4: if (b != 0) begin pu = ua / ub; p_lo = pu[31:0]; pu = ua % ub; p_hi = pu[31:0]; end
      default: ;
    endcase
  endtask

  task automatic model_update(input logic rst, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_pending = 0;
    end else if (m_pending) begin
      if (cyc == commit_cyc) begin
        m_hi = p_hi; m_lo = p_lo; m_pending = 0;
      end
    end else if (op >= 4'd1 && op <= 4'd4) begin
      model_compute(op, a, b);
      commit_cyc = cyc + ((op <= 4'd2) ? MULT_N : DIV_N);
      m_pending = 1;
    end else if (op == 4'd5) begin
      m_hi = a;
    end else if (op == 4'd6) begin
      m_lo = a;
    end
    cyc++;
  endtask

  // One cycle: drive at negedge, check comb/registered outputs, clock, update model
  task automatic apply_stimulus(input logic rst, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic dmd);
    logic e_start, e_stall;
    logic [31:0] e_read;
    reset = rst;
    bus.E_mdOp = op;
    bus.E_srcA = a;
    bus.E_srcB = b;
    bus.D_isMD = dmd;
    #1;
    e_start = (op >= 4'd1) && (op <= 4'd4) && !m_pending;
    e_stall = dmd && (e_start || m_pending);
    e_read  = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    check_output("busy", {31'd0, bus.busy}, {31'd0, m_pending});
    check_output("E_start", {31'd0, bus.E_start}, {31'd0, e_start});
    check_output("stall_req", {31'd0, bus.stall_req}, {31'd0, e_stall});
    check_output("E_mdRead", bus.E_mdRead, e_read);
    check_output("hi", bus.hi, m_hi);
    check_output("lo", bus.lo, m_lo);
    if (bus.stall_req === 1'b1) stall_count++;
    @(posedge clk);
    model_update(rst, op, a, b);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic dmd);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 4'd0, rand_word(), rand_word(), dmd);
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; commit_cyc = 0; stall_count = 0;
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_pending = 0;
    reset = 1'b1;
    bus.E_mdOp = 4'd0; bus.E_srcA = 32'd0; bus.E_srcB = 32'd0; bus.D_isMD = 1'b0;
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check_output("reset_hi", bus.hi, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);

    // D holds an MD op but E is empty and unit idle: no stall
    apply_stimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);

    // MULT -2 * 3
    apply_stimulus(1'b0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle_cycles(MULT_N, 1'b0);
    check_output("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check_output("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF * 2
    apply_stimulus(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle_cycles(MULT_N, 1'b0);
    check_output("multu_hi", bus.hi, 32'h0000_0001);
    check_output("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // DIV -7 / 2 with MFLO waiting in D
    stall_count = 0;
    apply_stimulus(1'b0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle_cycles(DIV_N, 1'b1);
    check_output("div_stall_cycles", 32'(stall_count), 32'(DIV_N + 1));
    check_output("div_hi", bus.hi, 32'hFFFF_FFFF);
    bus.E_mdOp = 4'd8; bus.D_isMD = 1'b0;
    #1;
    check_output("mflo_after_div", bus.E_mdRead, 32'hFFFF_FFFD);
    check_output("mflo_no_stall", {31'd0, bus.stall_req}, 32'd0);
    #1;
    apply_stimulus(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);

    // DIVU 7 / 0 leaves HI/LO unchanged after a full divide latency
    apply_stimulus(1'b0, 4'd4, 32'd7, 32'd0, 1'b0);
    idle_cycles(DIV_N, 1'b0);
    check_output("divu0_hi", bus.hi, 32'hFFFF_FFFF);
    check_output("divu0_lo", bus.lo, 32'hFFFF_FFFD);

    // DIV overflow case
    apply_stimulus(1'b0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_cycles(DIV_N, 1'b0);
    check_output("divovf_lo", bus.lo, 32'h8000_0000);
    check_output("divovf_hi", bus.hi, 32'd0);

    // MTHI at idle, then MTLO while busy is ignored
    apply_stimulus(1'b0, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
    check_output("mthi", bus.hi, 32'h1234_5678);
    apply_stimulus(1'b0, 4'd6, 32'hCAFE_0001, 32'd0, 1'b0);
    check_output("mtlo_idle", bus.lo, 32'hCAFE_0001);
    apply_stimulus(1'b0, 4'd2, 32'd3, 32'd4, 1'b0);
    apply_stimulus(1'b0, 4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check_output("mtlo_busy", bus.lo, 32'hCAFE_0001);
    idle_cycles(MULT_N, 1'b0);
    check_output("multu_small_lo", bus.lo, 32'd12);

    // Reset three cycles into a DIV aborts it
    apply_stimulus(1'b0, 4'd3, 32'd100, 32'd7, 1'b0);
    idle_cycles(2, 1'b0);
    apply_stimulus(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_output("abort_lo", bus.lo, 32'd0);
    idle_cycles(DIV_N + 2, 1'b0);
    check_output("abort_no_commit_hi", bus.hi, 32'd0);
    check_output("abort_no_commit_lo", bus.lo, 32'd0);

    // Randomized op stream
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] op;
      logic rst;
      op  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 149) == 0);
      apply_stimulus(rst, op, rand_word(), rand_word(), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
